// File: rtl/cla_accumulator_x64.sv
// cla_accumulator_x64: sequential accumulate controller wrapped around an
// external 64-bit carry-lookahead adder. Operands arrive on a valid/ready
// stream. Each operand is added to a running accumulator, and the batch
// result is presented on an output handshake.
// Optional feature: define CLA_ACC_SATURATE_EN to make the sum stick at
// all-ones once any add in the batch has carried out of bit 63.
module cla_accumulator_x64 #(
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [63:0]            in_data_i,
    input  logic                   in_last_i,
    output logic [63:0]            add_a_o,
    output logic [63:0]            add_b_o,
    input  logic [63:0]            add_s_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [63:0]            out_sum_o,
    output logic                   out_carry_o,
    output logic [COUNT_WIDTH-1:0] out_count_o
);

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e                 state_q, state_d;
    logic [63:0]            acc_q, acc_d;
    logic [63:0]            opnd_q, opnd_d;
    logic                   last_q, last_d;
    logic                   carry_q, carry_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   cout;

    // The adder exposes no carry-out, so recover it from the operand and
    // sum MSBs.
    assign cout = (add_a_o[63] & add_b_o[63]) |
                  ((add_a_o[63] ^ add_b_o[63]) & ~add_s_i[63]);

    // The adder inputs and all result outputs come straight from registers.
    assign add_a_o     = acc_q;
    assign add_b_o     = opnd_q;
    assign out_sum_o   = acc_q;
    assign out_carry_o = carry_q;
    assign out_count_o = count_q;
    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);

    // Next-state logic: accept an operand, add it, or hold the result.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        last_d  = last_q;
        carry_d = carry_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    opnd_d  = in_data_i;
                    last_d  = in_last_i;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                acc_d = add_s_i;
`ifdef CLA_ACC_SATURATE_EN
                if (cout || carry_q) begin
                    acc_d = '1;
                end
`endif
                carry_d = carry_q | cout;
                if (count_q != '1) begin
                    count_d = count_q + 1'b1;
                end
                state_d = last_q ? StDone : StIdle;
            end
            StDone: begin
                if (out_ready_i) begin
                    acc_d   = '0;
                    opnd_d  = '0;
                    carry_d = 1'b0;
                    count_d = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers. Reset is asynchronous and discards any partial batch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            acc_q   <= '0;
            opnd_q  <= '0;
            last_q  <= 1'b0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            last_q  <= last_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_cla_accumulator_x64.sv
// Self-checking bench for cla_accumulator_x64. The adder is modelled as a
// plain 64-bit add. Expected batch results are pushed when the last operand
// is transferred and are popped when the DUT presents a result.
module tb_cla_accumulator_x64;

    localparam int unsigned CW = 8;

    typedef struct packed {
        logic [63:0]   sum;
        logic          carry;
        logic [CW-1:0] count;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          in_last;
    logic [63:0]   add_a;
    logic [63:0]   add_b;
    logic [63:0]   add_s;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_sum;
    logic          out_carry;
    logic [CW-1:0] out_count;

    int checks = 0;
    int errors = 0;

    exp_t          sb[$];
    logic [63:0]   m_acc;
    logic          m_carry;
    logic [CW-1:0] m_cnt;

    always #5 clk = ~clk;

    // External carry-lookahead adder stand-in.
    assign add_s = add_a + add_b;

    cla_accumulator_x64 #(.COUNT_WIDTH(CW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .add_a_o     (add_a),
        .add_b_o     (add_b),
        .add_s_i     (add_s),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sum_o   (out_sum),
        .out_carry_o (out_carry),
        .out_count_o (out_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    task automatic model_reset();
        m_acc   = '0;
        m_carry = 1'b0;
        m_cnt   = '0;
    endtask

    // Reference arithmetic for one accepted operand.
    task automatic model_add(input logic [63:0] d, input logic l);
        logic [64:0] s;
        logic        prev;
        s       = {1'b0, m_acc} + {1'b0, d};
        prev    = m_carry;
        m_carry = m_carry | s[64];
`ifdef CLA_ACC_SATURATE_EN
        m_acc = (s[64] || prev) ? {64{1'b1}} : s[63:0];
`else
        m_acc = s[63:0];
`endif
        if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        if (l) begin
            sb.push_back('{sum: m_acc, carry: m_carry, count: m_cnt});
            model_reset();
        end
    endtask

    // Offer one operand; keep leaves IN_VALID high for back-to-back streams.
    task automatic send(input logic [63:0] d, input logic l, input logic keep);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            timeout("send_wait_ready");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
        model_add(d, l);
        check("in_ready_low_after_xfer", {63'd0, in_ready}, 64'd0);
        if (l) begin
            check("out_valid_low_at_xfer", {63'd0, out_valid}, 64'd0);
            @(posedge clk);
            #1;
            check("out_valid_high_next", {63'd0, out_valid}, 64'd1);
        end
    endtask

    // Accept one result and compare it against the scoreboard head.
    task automatic recv();
        int   t = 0;
        exp_t e;
        out_ready = 1'b1;
        while (!out_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!out_valid) begin
            timeout("recv_wait_valid");
            out_ready = 1'b0;
            return;
        end
        if (sb.size() == 0) begin
            timeout("recv_scoreboard_empty");
            out_ready = 1'b0;
            return;
        end
        e = sb.pop_front();
        check("out_sum", out_sum, e.sum);
        check("out_carry", {63'd0, out_carry}, {63'd0, e.carry});
        check("out_count", {56'd0, out_count}, {56'd0, e.count});
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("in_ready_after_out", {63'd0, in_ready}, 64'd1);
        check("out_valid_after_out", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #3;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_sum", out_sum, 64'd0);
        check("rst_out_count", {56'd0, out_count}, 64'd0);
        check("rst_add_b", add_b, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 5 + 7
        send(64'd5, 1'b0, 1'b0);
        send(64'd7, 1'b1, 1'b0);
        recv();

        // Wrap with carry out of bit 63.
        send({64{1'b1}}, 1'b0, 1'b0);
        send(64'd2, 1'b1, 1'b0);
        recv();

        // Single operand held in DONE; an IN_VALID pulse must be ignored.
        send(64'h1234, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("hold_out_sum", out_sum, 64'h1234);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            if (i == 1) begin
                in_valid = 1'b1;
                in_data  = 64'd9;
                in_last  = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        recv();

        // Count saturation over a long batch.
        for (int i = 0; i < 300; i++) begin
            send(64'd1, (i == 299), 1'b0);
        end
        recv();

        // Asynchronous reset in the middle of a batch.
        send(64'd10, 1'b0, 1'b0);
        send(64'd20, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_rst_add_a", add_a, 64'd30);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_add_a", add_a, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(64'd3, 1'b1, 1'b0);
        recv();

        // Back-to-back with IN_VALID held high.
        send(64'd1, 1'b0, 1'b1);
        send(64'd2, 1'b0, 1'b1);
        send(64'd3, 1'b1, 1'b0);
        recv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
